// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and EX-resolve signal bundle for branch_predict_unit.
// master = pipeline side, slave = predictor.
interface branch_predict_unit_if;
    logic [31:0] i_if_pc;
    logic        o_if_pred_taken;
    logic [31:0] o_if_pred_target;
    logic        i_ex_valid;
    logic        i_stall;
    logic [31:0] i_ex_inst;
    logic [31:0] i_ex_pc;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic [31:0] i_ex_target;
    logic        i_br_lt;
    logic        i_br_eq;
    logic        o_br_un;
    logic        o_ex_taken;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;

    modport master (
        output i_if_pc, i_ex_valid, i_stall, i_ex_inst, i_ex_pc,
        output i_ex_pred_taken, i_ex_pred_target, i_ex_target,
        output i_br_lt, i_br_eq,
        input  o_if_pred_taken, o_if_pred_target, o_br_un,
        input  o_ex_taken, o_redirect, o_redirect_pc
    );

    modport slave (
        input  i_if_pc, i_ex_valid, i_stall, i_ex_inst, i_ex_pc,
        input  i_ex_pred_taken, i_ex_pred_target, i_ex_target,
        input  i_br_lt, i_br_eq,
        output o_if_pred_taken, o_if_pred_target, o_br_un,
        output o_ex_taken, o_redirect, o_redirect_pc
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT/BTB with zero-cycle lookup and EX-stage resolution.
// Define BPU_PERF_CNT_EN to add branch / mispredict counters.
module branch_predict_unit #(
    parameter int BHT_DEPTH = 64,
    parameter int CTR_W     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
`ifdef BPU_PERF_CNT_EN
    output logic [31:0]          o_br_cnt,
    output logic [31:0]          o_mispred_cnt,
`endif
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX >> 1;
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

    logic [CTR_W-1:0]     ctr_q [BHT_DEPTH];
    logic [TAG_W-1:0]     tag_q [BHT_DEPTH];
    logic [31:0]          tgt_q [BHT_DEPTH];
    logic [BHT_DEPTH-1:0] vld_q;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic [4:0]       opc;
    logic [2:0]       f3;
    logic             is_br, is_jmp, is_ctrl;
    logic             br_cond, br_un, ex_taken, ex_go;
    logic             ex_hit, wr_ctr, wr_ent, clr_vld;
    logic [CTR_W-1:0] ctr_base, ctr_nxt;
    logic             unused_bits;

    assign if_idx = bus.i_if_pc[IDX_W+1:2];
    assign if_tag = bus.i_if_pc[31:IDX_W+2];
    assign ex_idx = bus.i_ex_pc[IDX_W+1:2];
    assign ex_tag = bus.i_ex_pc[31:IDX_W+2];
    assign opc    = bus.i_ex_inst[6:2];
    assign f3     = bus.i_ex_inst[14:12];

    assign unused_bits = &{1'b0, bus.i_ex_inst[31:15],
                           bus.i_ex_inst[11:7],
                           bus.i_ex_inst[1:0], bus.i_if_pc[1:0]};

    // Lookup reads registered state only; a same-cycle update is not bypassed.
    assign bus.o_if_pred_taken  = vld_q[if_idx]
                                & (tag_q[if_idx] == if_tag)
                                & ctr_q[if_idx][CTR_W-1];
    assign bus.o_if_pred_target = tgt_q[if_idx];

    assign is_br   = (opc == 5'b11000);
    assign is_jmp  = (opc == 5'b11011) | (opc == 5'b11001);
    assign is_ctrl = is_br | is_jmp;

    always_comb begin
        br_cond = 1'b0;
        br_un   = 1'b0;
        unique case (f3)
            3'b000: br_cond = bus.i_br_eq;
            3'b001: br_cond = ~bus.i_br_eq;
            3'b100: br_cond = bus.i_br_lt;
            3'b101: br_cond = ~bus.i_br_lt;
            3'b110: begin br_cond = bus.i_br_lt;  br_un = 1'b1; end
            3'b111: begin br_cond = ~bus.i_br_lt; br_un = 1'b1; end
            3'b010, 3'b011: br_cond = 1'b0;
        endcase
    end

    assign ex_taken       = is_jmp | (is_br & br_cond);
    assign bus.o_ex_taken = ex_taken;
    assign bus.o_br_un    = is_br & br_un;
    assign ex_go          = bus.i_ex_valid & ~bus.i_stall;

    assign bus.o_redirect = ex_go & (
          (is_ctrl & (ex_taken != bus.i_ex_pred_taken))
        | (ex_taken & bus.i_ex_pred_taken
           & (bus.i_ex_target != bus.i_ex_pred_target))
        | (~is_ctrl & bus.i_ex_pred_taken));

    assign bus.o_redirect_pc = ex_taken ? bus.i_ex_target
                                        : bus.i_ex_pc + 32'd4;

    // A branch landing on another PC's entry restarts from the reset count.
    always_comb begin
        ex_hit   = vld_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ctr_base = ex_hit ? ctr_q[ex_idx] : CTR_INIT;
        ctr_nxt  = ctr_base;
        wr_ctr   = 1'b0;
        wr_ent   = 1'b0;
        clr_vld  = 1'b0;
        if (is_jmp) begin
            ctr_nxt = CTR_MAX;
            wr_ctr  = 1'b1;
            wr_ent  = 1'b1;
        end else if (is_br && ex_taken) begin
            if (ctr_base != CTR_MAX) ctr_nxt = ctr_base + CTR_ONE;
            wr_ctr = 1'b1;
            wr_ent = 1'b1;
        end else if (is_br) begin
            if (ctr_base != '0) ctr_nxt = ctr_base - CTR_ONE;
            wr_ctr = 1'b1;
        end else if (bus.i_ex_pred_taken) begin
            clr_vld = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_q <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= CTR_INIT;
        end else if (ex_go) begin
            if (wr_ctr) ctr_q[ex_idx] <= ctr_nxt;
            if (wr_ent) vld_q[ex_idx] <= 1'b1;
            else if (clr_vld) vld_q[ex_idx] <= 1'b0;
        end
    end

    // Tag/target need no reset: they are only observed through valid.
    always_ff @(posedge i_clk) begin
        if (ex_go && wr_ent) begin
            tag_q[ex_idx] <= ex_tag;
            tgt_q[ex_idx] <= bus.i_ex_target;
        end
    end

`ifdef BPU_PERF_CNT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_br_cnt      <= '0;
            o_mispred_cnt <= '0;
        end else begin
            if (ex_go && is_ctrl) o_br_cnt <= o_br_cnt + 32'd1;
            if (bus.o_redirect) o_mispred_cnt <= o_mispred_cnt + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; expectations go through a queue.
// Perf-counter checks are compiled in only with BPU_PERF_CNT_EN.
module tb_branch_predict_unit;
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] o_br_cnt, o_mispred_cnt;
`endif

    branch_predict_unit_if bus ();

    branch_predict_unit #(.BHT_DEPTH(64), .CTR_W(2)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
`ifdef BPU_PERF_CNT_EN
        .o_br_cnt      (o_br_cnt),
        .o_mispred_cnt (o_mispred_cnt),
`endif
        .bus     (bus.master)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] JALR = 32'h0000_0067;
    localparam logic [31:0] ADD  = 32'h0000_0033;

    function automatic logic [31:0] br(input logic [2:0] f3);
        return {17'b0, f3, 5'b0, 7'h63};
    endfunction

    task automatic push(input string t, input logic [63:0] e);
        exp_t x;
        x.tag = t;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty observed=%0h required=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s observed=%0h required=%0h",
                        e.tag, obs, e.exp);
        end
    endtask

    task automatic lookup(input string t, input logic [31:0] pc,
                          input logic exp_tk, input logic [31:0] exp_tgt);
        bus.i_if_pc = pc;
        push({t, ".pred"}, 64'(exp_tk));
        #1;
        pop_check(64'(bus.o_if_pred_taken));
        if (exp_tk) begin
            push({t, ".tgt"}, 64'(exp_tgt));
            pop_check(64'(bus.o_if_pred_target));
        end
    endtask

    task automatic ex(input string t, input logic v, input logic st,
                      input logic [31:0] inst, input logic [31:0] pc,
                      input logic pt, input logic [31:0] ptgt,
                      input logic [31:0] tgt, input logic lt,
                      input logic eq, input logic e_tk, input logic e_un,
                      input logic e_rd, input logic [31:0] e_rpc);
        @(negedge i_clk);
        bus.i_ex_valid       = v;
        bus.i_stall          = st;
        bus.i_ex_inst        = inst;
        bus.i_ex_pc          = pc;
        bus.i_ex_pred_taken  = pt;
        bus.i_ex_pred_target = ptgt;
        bus.i_ex_target      = tgt;
        bus.i_br_lt          = lt;
        bus.i_br_eq          = eq;
        push({t, ".taken"}, 64'(e_tk));
        push({t, ".un"},    64'(e_un));
        push({t, ".redir"}, 64'(e_rd));
        push({t, ".rpc"},   64'(e_rpc));
        #1;
        pop_check(64'(bus.o_ex_taken));
        pop_check(64'(bus.o_br_un));
        pop_check(64'(bus.o_redirect));
        pop_check(64'(bus.o_redirect_pc));
        @(posedge i_clk);
        #1;
        bus.i_ex_valid = 1'b0;
        bus.i_stall    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1);
    end

    initial begin
        bus.i_if_pc          = 32'h0;
        bus.i_ex_valid       = 1'b0;
        bus.i_stall          = 1'b0;
        bus.i_ex_inst        = 32'h0;
        bus.i_ex_pc          = 32'h0;
        bus.i_ex_pred_taken  = 1'b0;
        bus.i_ex_pred_target = 32'h0;
        bus.i_ex_target      = 32'h0;
        bus.i_br_lt          = 1'b0;
        bus.i_br_eq          = 1'b0;

        #12;
        lookup("rst_lookup", 32'h100, 1'b0, 32'h0);
`ifdef BPU_PERF_CNT_EN
        push("rst_brcnt", 64'd0);
        pop_check(64'(o_br_cnt));
`endif
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        lookup("cold_100", 32'h100, 1'b0, 32'h0);
        ex("beq_100", 1, 0, br(3'd0), 32'h100, 0, 32'h0, 32'h200,
           0, 1, 1, 0, 1, 32'h200);
        lookup("warm_100", 32'h100, 1'b1, 32'h200);

        ex("bne_t0", 1, 0, br(3'd1), 32'h40, 0, 32'h0, 32'h500,
           0, 0, 1, 0, 1, 32'h500);
        for (int k = 1; k < 5; k++)
            ex("bne_tk", 1, 0, br(3'd1), 32'h40, 1, 32'h500, 32'h500,
               0, 0, 1, 0, 0, 32'h500);
        lookup("bne_sat", 32'h40, 1'b1, 32'h500);
        ex("bne_nt1", 1, 0, br(3'd1), 32'h40, 1, 32'h500, 32'h500,
           0, 1, 0, 0, 1, 32'h44);
        lookup("bne_ctr2", 32'h40, 1'b1, 32'h500);
        ex("bne_nt2", 1, 0, br(3'd1), 32'h40, 1, 32'h500, 32'h500,
           0, 1, 0, 0, 1, 32'h44);
        lookup("bne_ctr1", 32'h40, 1'b0, 32'h0);

        ex("bltu", 1, 0, br(3'd6), 32'h60, 0, 32'h0, 32'h700,
           1, 0, 1, 1, 1, 32'h700);
        ex("bge", 1, 0, br(3'd5), 32'h64, 0, 32'h0, 32'h800,
           1, 0, 0, 0, 0, 32'h68);
        ex("f3_010", 1, 0, br(3'd2), 32'h68, 0, 32'h0, 32'h900,
           1, 1, 0, 0, 0, 32'h6C);
        ex("bgeu", 1, 0, br(3'd7), 32'h6C, 0, 32'h0, 32'h777,
           0, 0, 1, 1, 1, 32'h777);

        ex("jalr", 1, 0, JALR, 32'h80, 1, 32'h300, 32'h340,
           0, 0, 1, 0, 1, 32'h340);
        lookup("jalr_tgt", 32'h80, 1'b1, 32'h340);
        ex("jal", 1, 0, JAL, 32'h90, 0, 32'h0, 32'h900,
           0, 0, 1, 0, 1, 32'h900);
        lookup("jal_tgt", 32'h90, 1'b1, 32'h900);

        ex("add_alias", 1, 0, ADD, 32'h100, 1, 32'h200, 32'h0,
           0, 0, 0, 0, 1, 32'h104);
        lookup("add_inval", 32'h100, 1'b0, 32'h0);

        ex("blt_stall", 1, 1, br(3'd4), 32'hC0, 0, 32'h0, 32'hC00,
           1, 0, 1, 0, 0, 32'hC00);
        lookup("stall_noupd", 32'hC0, 1'b0, 32'h0);
        ex("jal_novld", 0, 0, JAL, 32'hD0, 0, 32'h0, 32'hD00,
           0, 0, 1, 0, 0, 32'hD00);
        lookup("novld_noupd", 32'hD0, 1'b0, 32'h0);

        lookup("tag_miss", 32'h140, 1'b0, 32'h0);
        ex("beq_140", 1, 0, br(3'd0), 32'h140, 0, 32'h0, 32'h600,
           0, 1, 1, 0, 1, 32'h600);
        lookup("tag_new", 32'h140, 1'b1, 32'h600);
        lookup("tag_old", 32'h40, 1'b0, 32'h0);

        ex("pc_wrap", 1, 0, ADD, 32'hFFFF_FFFC, 1, 32'h10, 32'h0,
           0, 0, 0, 0, 1, 32'h0);

        // Reset lands mid-cycle while a JAL sits in EX.
        @(negedge i_clk);
        bus.i_ex_valid       = 1'b1;
        bus.i_ex_inst        = JAL;
        bus.i_ex_pc          = 32'hA0;
        bus.i_ex_pred_taken  = 1'b0;
        bus.i_ex_target      = 32'hA00;
        #2;
        i_reset = 1'b1;
        #1;
        push("rst_redir", 64'd1);
        pop_check(64'(bus.o_redirect));
        lookup("rst_async", 32'h80, 1'b0, 32'h0);
`ifdef BPU_PERF_CNT_EN
        push("rst_br0", 64'd0);
        pop_check(64'(o_br_cnt));
        push("rst_mp0", 64'd0);
        pop_check(64'(o_mispred_cnt));
`endif
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        bus.i_ex_valid = 1'b0;
        lookup("rst_discard", 32'hA0, 1'b0, 32'h0);
        lookup("rst_jal", 32'h90, 1'b0, 32'h0);

        for (int k = 0; k < 10; k++) begin
            if (k < 3)
                ex("perf_mp", 1, 0, br(3'd0), 32'h1000 + 32'(4 * k),
                   0, 32'h0, 32'h2000, 0, 1, 1, 0, 1, 32'h2000);
            else
                ex("perf_ok", 1, 0, br(3'd0), 32'h1000 + 32'(4 * k),
                   0, 32'h0, 32'h2000, 0, 0, 0, 0, 0,
                   32'h1004 + 32'(4 * k));
        end
`ifdef BPU_PERF_CNT_EN
        push("perf_br", 64'd10);
        pop_check(64'(o_br_cnt));
        push("perf_mp", 64'd3);
        pop_check(64'(o_mispred_cnt));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter BHT_DEPTH, default 64, number of predictor entries (power of two, 4..1024).
REQ-002 SHALL have parameter CTR_W, default 2, saturating-counter width (2..4).
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_if_pc  input  32  fetch-stage PC to look up.
REQ-006 SHALL have port o_if_pred_taken  output  1  fetch prediction: redirect fetch to o_if_pred_target.
REQ-007 SHALL have port o_if_pred_target  output  32  predicted target.
REQ-008 SHALL have port i_ex_valid  input  1  EX stage holds a valid instruction.
REQ-009 SHALL have port i_stall  input  1  EX stage frozen; blocks all state updates.
REQ-010 SHALL have port i_ex_inst  input  32  EX-stage instruction.
REQ-011 SHALL have port i_ex_pc  input  32  EX-stage PC.
REQ-012 SHALL have port i_ex_pred_taken  input  1  prediction carried down from fetch.
REQ-013 SHALL have port i_ex_pred_target  input  32  predicted target carried down from fetch.
REQ-014 SHALL have port i_ex_target  input  32  resolved target from the ALU.
REQ-015 SHALL have ports i_br_lt, i_br_eq  input  1 each  comparator results.
REQ-016 SHALL have port o_br_un  output  1  1 = unsigned compare (BLTU/BGEU).
REQ-017 SHALL have port o_ex_taken  output  1  resolved direction (JAL/JALR always 1).
REQ-018 SHALL have port o_redirect  output  1  mispredict; flush and refetch.
REQ-019 SHALL have port o_redirect_pc  output  32  correct next PC.

Function
REQ-020 SHALL decode opcode[6:2] 11000 = branch, 11011 = JAL, 11001 = JALR; funct3 selects BEQ/BNE/BLT/BGE/BLTU/BGEU; undefined funct3 (010, 011) resolves not-taken.
REQ-021 SHALL compute o_ex_taken and o_br_un combinationally from the EX inputs; both are 0 for non-control instructions.
REQ-022 SHALL index state by pc[log2(BHT_DEPTH)+1:2]; tag = pc[31:log2(BHT_DEPTH)+2].
REQ-023 SHALL hold per entry: CTR_W-bit counter, valid bit, tag, 32-bit target.
REQ-024 SHALL drive o_if_pred_taken = valid & tag match & counter MSB, combinationally from registered state (zero-cycle lookup); o_if_pred_target = stored target.
REQ-025 SHALL assert o_redirect when i_ex_valid & ~i_stall and: control & (taken != pred_taken); or taken & pred_taken & (i_ex_target != i_ex_pred_target); or non-control & pred_taken.
REQ-026 SHALL drive o_redirect_pc = i_ex_target when taken, else i_ex_pc + 4 (mod 2^32).
REQ-027 SHALL update state one edge after a valid, unstalled EX cycle; no update when i_ex_valid = 0 or i_stall = 1.
REQ-028 Taken branch: counter +1 saturating at 2^CTR_W-1; write tag, target, valid = 1.
REQ-029 Not-taken branch: counter -1 saturating at 0; target, tag and valid unchanged.
REQ-030 JAL/JALR: counter forced to 2^CTR_W-1; write tag, target, valid = 1.
REQ-031 Non-control instruction with i_ex_pred_taken = 1: clear valid of its entry (alias eviction).
REQ-032 Tag mismatch on a branch update: reinitialise counter to the reset value, then apply REQ-028/029.
REQ-033 Same-cycle lookup and update of the same index: lookup returns pre-update state (no bypass).

Reset
REQ-034 On i_reset, asynchronously: all valid = 0, counters = 2^(CTR_W-1)-1 (weakly not-taken), perf counters = 0.
REQ-035 During reset: o_if_pred_taken = 0; o_redirect, o_ex_taken and o_br_un follow inputs combinationally, and no updates occur.
REQ-036 Reset asserted mid-update SHALL discard the pending update.

Configuration
REQ-037 With macro BPU_PERF_CNT_EN defined, SHALL add outputs o_br_cnt (32) and o_mispred_cnt (32), incremented per valid, unstalled resolved control instruction and per o_redirect respectively, wrapping at 2^32.
REQ-038 Without BPU_PERF_CNT_EN, SHALL omit these ports and their registers.

Verification
REQ-039 After reset: lookup pc 0x100 -> o_if_pred_taken = 0; BEQ at 0x100 with eq = 1, pred 0, target 0x200 -> o_redirect = 1, o_redirect_pc = 0x200; next cycle lookup 0x100 -> taken, target 0x200.
REQ-040 BNE at 0x40 taken 5 times, then not-taken once, CTR_W = 2 -> counter 3, 2; lookup still predicts taken; second not-taken -> 1, predicts not-taken.
REQ-041 JALR at 0x80, pred taken to 0x300, actual 0x340 -> o_redirect = 1, o_redirect_pc = 0x340, entry target becomes 0x340.
REQ-042 ADD at 0x100 arriving with pred_taken = 1 -> o_redirect = 1, o_redirect_pc = 0x104, entry 0x100 invalidated.
REQ-043 i_stall = 1 with a taken BLT -> no state change; i_reset pulse mid-sequence -> all predictions 0 and perf counters 0 asynchronously.
REQ-044 BPU_PERF_CNT_EN defined: 10 branches with 3 mispredicts -> o_br_cnt = 10, o_mispred_cnt = 3.
